// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-generation stage.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  // Encoding is {out_valid, skid_valid} so the flags fall straight out of the state register.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StFull  = 2'b10,
    StSkid  = 2'b11
  } state_e;

  localparam logic [6:0] OPC_LOAD       = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM   = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
  localparam logic [6:0] OPC_STORE      = 7'b0100011;
  localparam logic [6:0] OPC_OP         = 7'b0110011;
  localparam logic [6:0] OPC_LUI        = 7'b0110111;
  localparam logic [6:0] OPC_OP_32      = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
  localparam logic [6:0] OPC_JALR       = 7'b1100111;
  localparam logic [6:0] OPC_JAL        = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM     = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational format classification and sign-extended immediate extraction.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);

  fmt_e        w_fmt;
  logic [31:0] w_imm32;
  logic        w_s;

  assign w_s = i_instr[31];

  always_comb begin
    w_fmt = FMT_NONE;
    case (i_instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: w_fmt = FMT_I;
      OPC_STORE:             w_fmt = FMT_S;
      OPC_BRANCH:            w_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:    w_fmt = FMT_U;
      OPC_JAL:               w_fmt = FMT_J;
      OPC_OP:                w_fmt = FMT_R;
      OPC_OP_IMM_32: if (XLEN == 64) w_fmt = FMT_I;
      OPC_OP_32:     if (XLEN == 64) w_fmt = FMT_R;
      default:               w_fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{w_s}}, i_instr[31:20]};
      FMT_S: w_imm32 = {{20{w_s}}, i_instr[31:25], i_instr[11:7]};
      FMT_B: w_imm32 = {{19{w_s}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_U: w_imm32 = {i_instr[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{w_s}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21],
                        1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Every 32-bit immediate already carries instr[31] in bit 31, so widen from there.
  always_comb begin
    o_imm       = {XLEN{w_imm32[31]}};
    o_imm[31:0] = w_imm32;
  end

  assign o_fmt     = w_fmt;
  assign o_illegal = (w_fmt == FMT_NONE);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: decode + PC-relative adder behind a two-entry skid buffer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic [XLEN-1:0] o_target,
  output logic            o_illegal
);

  localparam int unsigned BeatW = 32 + 3 * XLEN + 4;
  localparam logic [BeatW-1:0] ResetBeat = {{(32 + 2 * XLEN){1'b0}}, FMT_NONE, {(XLEN + 1){1'b0}}};

  logic [XLEN-1:0]  w_imm;
  logic [2:0]       w_fmt;
  logic             w_illegal;
  logic [XLEN-1:0]  w_target;
  logic [BeatW-1:0] w_beat;

  state_e           r_state;
  state_e           w_state_next;
  logic [BeatW-1:0] r_out_beat;
  logic [BeatW-1:0] r_skid_beat;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_out;
  logic             w_load_skid;
  logic             w_skid_to_out;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .i_instr   (i_instr),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_illegal)
  );

  assign w_target = i_pc + w_imm;
  assign w_beat   = {i_instr, i_pc, w_imm, w_fmt, w_target, w_illegal};

  assign o_valid    = r_state[1];
  assign o_ready    = ~r_state[0];
  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;

  always_comb begin
    w_state_next  = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      StEmpty: begin
        if (w_in_fire) begin
          w_state_next = StFull;
          w_load_out   = 1'b1;
        end
      end
      StFull: begin
        if (w_in_fire && w_out_fire) begin
          w_load_out = 1'b1;
        end else if (w_in_fire) begin
          w_state_next = StSkid;
          w_load_skid  = 1'b1;
        end else if (w_out_fire) begin
          w_state_next = StEmpty;
        end
      end
      StSkid: begin
        if (w_out_fire) begin
          w_state_next  = StFull;
          w_skid_to_out = 1'b1;
        end
      end
      default: w_state_next = StEmpty;
    endcase
    // Flush wins: any beat accepted this cycle is dropped along with held ones.
    if (i_flush) begin
      w_state_next  = StEmpty;
      w_load_out    = 1'b0;
      w_load_skid   = 1'b0;
      w_skid_to_out = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_beat  <= ResetBeat;
      r_skid_beat <= ResetBeat;
    end else begin
      if (w_load_out) begin
        r_out_beat <= w_beat;
      end else if (w_skid_to_out) begin
        r_out_beat <= r_skid_beat;
      end
      if (w_load_skid) begin
        r_skid_beat <= w_beat;
      end
    end
  end

  assign {o_instr, o_pc, o_imm, o_fmt, o_target, o_illegal} = r_out_beat;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] d_instr = '0;
  logic [63:0] d_pc = '0;

  logic        v32 = 1'b0, dn32 = 1'b1, rdy32, ov32, ill32;
  logic [31:0] instr32, pc32, imm32, tgt32;
  logic [2:0]  fmt32;

  logic        v64 = 1'b0, dn64 = 1'b1, rdy64, ov64, ill64;
  logic [31:0] instr64;
  logic [63:0] pc64, imm64, tgt64;
  logic [2:0]  fmt64;

  exp_t sb32[$];
  exp_t sb64[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_valid(v32), .o_ready(rdy32),
    .i_instr(d_instr), .i_pc(d_pc[31:0]), .o_valid(ov32), .i_ready(dn32),
    .o_instr(instr32), .o_pc(pc32), .o_imm(imm32), .o_fmt(fmt32), .o_target(tgt32),
    .o_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_valid(v64), .o_ready(rdy64),
    .i_instr(d_instr), .i_pc(d_pc), .o_valid(ov64), .i_ready(dn64),
    .o_instr(instr64), .o_pc(pc64), .o_imm(imm64), .o_fmt(fmt64), .o_target(tgt64),
    .o_illegal(ill64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit use64, input logic [31:0] instr, input logic [63:0] pc,
                      input logic [63:0] imm, input logic [2:0] fmt, input logic [63:0] tgt,
                      input logic ill);
    int   n = 0;
    exp_t e;
    d_instr = instr;
    d_pc    = pc;
    if (use64) v64 = 1'b1; else v32 = 1'b1;
    while (!(use64 ? rdy64 : rdy32)) begin
      step();
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: instr 0x%08h never accepted", instr);
        break;
      end
    end
    e = '{instr: instr, pc: pc, imm: imm, fmt: fmt, tgt: tgt, ill: ill};
    if (use64) sb64.push_back(e); else sb32.push_back(e);
    step();
    v32 = 1'b0;
    v64 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb32.size() != 0) || (sb64.size() != 0)) begin
      step();
      n++;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL drain_timeout: got %0d/%0d beats left want 0/0", sb32.size(), sb64.size());
        break;
      end
    end
  endtask

  // Transfers happen on the next rising edge; outputs are stable at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov32 && dn32) begin
      if (sb32.size() == 0) begin
        total++;
        bad++;
        $display("FAIL m32_unexpected: got instr 0x%08h want no beat", instr32);
      end else begin
        e = sb32.pop_front();
        chk("m32_instr", {32'h0, instr32}, {32'h0, e.instr});
        chk("m32_pc", {32'h0, pc32}, e.pc);
        chk("m32_imm", {32'h0, imm32}, e.imm);
        chk("m32_fmt", {61'h0, fmt32}, {61'h0, e.fmt});
        chk("m32_target", {32'h0, tgt32}, e.tgt);
        chk("m32_illegal", {63'h0, ill32}, {63'h0, e.ill});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov64 && dn64) begin
      if (sb64.size() == 0) begin
        total++;
        bad++;
        $display("FAIL m64_unexpected: got instr 0x%08h want no beat", instr64);
      end else begin
        e = sb64.pop_front();
        chk("m64_instr", {32'h0, instr64}, {32'h0, e.instr});
        chk("m64_pc", pc64, e.pc);
        chk("m64_imm", imm64, e.imm);
        chk("m64_fmt", {61'h0, fmt64}, {61'h0, e.fmt});
        chk("m64_target", tgt64, e.tgt);
        chk("m64_illegal", {63'h0, ill64}, {63'h0, e.ill});
      end
    end
  end

  initial begin
    repeat (3) step();
    chk("rst_valid", {63'h0, ov32}, 64'h0);
    chk("rst_ready", {63'h0, rdy32}, 64'h1);
    chk("rst_imm", {32'h0, imm32}, 64'h0);
    chk("rst_target", {32'h0, tgt32}, 64'h0);
    chk("rst_pc", {32'h0, pc32}, 64'h0);
    chk("rst_instr", {32'h0, instr32}, 64'h0);
    chk("rst_fmt", {61'h0, fmt32}, 64'h7);
    chk("rst_illegal", {63'h0, ill32}, 64'h0);
    chk("rst_valid64", {63'h0, ov64}, 64'h0);
    rst_n = 1'b1;
    step();

    // Streaming at full rate, XLEN=32.
    send(0, 32'hFFF00093, 64'h0,    64'hFFFFFFFF, 3'd1, 64'hFFFFFFFF, 1'b0);
    chk("latency_valid", {63'h0, ov32}, 64'h1);
    send(0, 32'hFE000EE3, 64'h100,  64'hFFFFFFFC, 3'd3, 64'hFC,       1'b0);
    send(0, 32'h123452B7, 64'hFFC,  64'h12345000, 3'd4, 64'h12345FFC, 1'b0);
    send(0, 32'h0010006F, 64'h1000, 64'h800,      3'd5, 64'h1800,     1'b0);
    send(0, 32'hFE112E23, 64'h200,  64'hFFFFFFFC, 3'd2, 64'h1FC,      1'b0);
    send(0, 32'h002081B3, 64'h300,  64'h0,        3'd0, 64'h300,      1'b0);
    send(0, 32'h00000000, 64'h400,  64'h0,        3'd7, 64'h400,      1'b1);
    send(0, 32'h00000001, 64'h10,   64'h0,        3'd7, 64'h10,       1'b1);
    send(0, 32'h0010001B, 64'h8,    64'h0,        3'd7, 64'h8,        1'b1);
    drain();

    // Backpressure: third beat must wait upstream until the skid drains.
    dn32 = 1'b0;
    send(0, 32'h00A00093, 64'h20, 64'hA,        3'd1, 64'h2A, 1'b0);
    send(0, 32'hFFF00093, 64'h24, 64'hFFFFFFFF, 3'd1, 64'h23, 1'b0);
    chk("bp_ready_low", {63'h0, rdy32}, 64'h0);
    d_instr = 32'h0010006F;
    d_pc    = 64'h28;
    v32     = 1'b1;
    step();
    chk("bp_hold1", {63'h0, rdy32}, 64'h0);
    step();
    chk("bp_hold2", {63'h0, rdy32}, 64'h0);
    dn32 = 1'b1;
    send(0, 32'h0010006F, 64'h28, 64'h800, 3'd5, 64'h828, 1'b0);
    drain();

    // Flush from the skid state, then flush racing an accept.
    dn32 = 1'b0;
    send(0, 32'h00000000, 64'h40, 64'h0, 3'd7, 64'h40, 1'b1);
    send(0, 32'h002081B3, 64'h44, 64'h0, 3'd0, 64'h44, 1'b0);
    chk("skid_valid", {63'h0, ov32}, 64'h1);
    chk("zero_illegal", {63'h0, ill32}, 64'h1);
    chk("zero_fmt", {61'h0, fmt32}, 64'h7);
    chk("zero_imm", {32'h0, imm32}, 64'h0);
    chk("zero_target", {32'h0, tgt32}, 64'h40);
    flush = 1'b1;
    step();
    flush = 1'b0;
    sb32.delete();
    chk("flush_valid", {63'h0, ov32}, 64'h0);
    chk("flush_ready", {63'h0, rdy32}, 64'h1);
    dn32    = 1'b1;
    d_instr = 32'hFFF00093;
    d_pc    = 64'h0;
    v32     = 1'b1;
    flush   = 1'b1;
    step();
    v32   = 1'b0;
    flush = 1'b0;
    chk("flush_drop", {63'h0, ov32}, 64'h0);
    step();
    chk("flush_drop2", {63'h0, ov32}, 64'h0);

    // XLEN=64 decode.
    send(1, 32'hFFF00093, 64'h0,  64'hFFFFFFFFFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send(1, 32'h0010001B, 64'h8,  64'h1,                3'd1, 64'h9,                1'b0);
    send(1, 32'h800002B7, 64'h0,  64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80000000, 1'b0);
    send(1, 32'h0000003B, 64'h10, 64'h0,                3'd0, 64'h10,               1'b0);
    send(1, 32'h00001017, 64'h20, 64'h1000,             3'd4, 64'h1020,             1'b0);
    drain();

    // Asynchronous reset with a beat held at the output.
    dn64 = 1'b0;
    send(1, 32'h00A00093, 64'h50, 64'hA, 3'd1, 64'h5A, 1'b0);
    chk("pre_rst_valid", {63'h0, ov64}, 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'h0, ov64}, 64'h0);
    chk("async_rst_ready", {63'h0, rdy64}, 64'h1);
    chk("async_rst_imm", imm64, 64'h0);
    sb64.delete();
    step();
    step();
    rst_n = 1'b1;
    dn64  = 1'b1;
    step();
    send(1, 32'hFFF00093, 64'h60, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'h5F, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
